agc_gain_ctrl: RTL
==================

Name: agc_gain_ctrl

Overview:
Closed-loop gain sequencer for the AGC datapath.
- Watches the post-gain sample stream and measures peak magnitude over fixed windows.
- Compares each window's peak to a programmable target with a deadband.
- Steps the gain word fed back to the datapath: fast attack when the signal is loud, slow release gated by a hold timer.
- Sits between the AGC datapath output and its gain input, inside the top-level wrapper.

Parameters:
DW, 8, sample width (signed two's complement)
GW, 8, gain width (unsigned, Q2.6; 64 = unity)
WIN_LOG2, 4, log2 of samples per measurement window (16)
HOLD, 4, quiet windows required before any release step
ATTACK_STEP, 8, gain decrement per loud window
RELEASE_STEP, 1, gain increment per quiet window after hold expiry
GAIN_INIT, 64, gain after reset
GAIN_MIN, 1, lower gain clamp
GAIN_MAX, 255, upper gain clamp

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
clk_enable  in  1  global enable; low freezes all state
samp_in  in  DW  post-gain datapath sample, signed
samp_valid  in  1  samp_in qualifier
target  in  DW-1  desired peak magnitude
hyst  in  4  deadband half-width
freeze  in  1  inhibit gain changes
gain  out  GW  gain word to datapath
gain_upd  out  1  one-cycle pulse when gain changes
state  out  2  FSM state: 00 IDLE, 01 MEASURE, 10 DECIDE, 11 UPDATE
clipping  out  1  last completed window hit full scale

Behaviour:
- Reset (async, rst_n low): gain=GAIN_INIT, gain_upd=0, state=IDLE, clipping=0, peak=0, sample count=0, hold count=0. A partial window is discarded.
- clk_enable low: no register changes. gain_upd output is ANDed with clk_enable so a stalled cycle never repeats the pulse.
- Magnitude: |samp_in|, saturating. -2^(DW-1) maps to 2^(DW-1)-1.
- IDLE: one enabled cycle, then MEASURE.
- MEASURE:
  - Each valid sample updates peak = max(peak, mag) and increments the count.
  - On the 2^WIN_LOG2-th sample, go to DECIDE; that sample is included in peak.
- DECIDE (1 cycle); samples arriving here are ignored:
  - freeze=1: next gain = gain; hold count unchanged.
  - peak > target+hyst (compare width DW bits, no overflow): next gain = max(gain-ATTACK_STEP, GAIN_MIN); hold count loaded with HOLD.
  - peak < target-hyst (floored at 0): if hold count=0, next gain = min(gain+RELEASE_STEP, GAIN_MAX); else hold count decrements.
  - Otherwise (in band): hold count decrements if nonzero; gain unchanged.
  - All gain arithmetic uses GW+1 bits before clamping.
- UPDATE (1 cycle); samples arriving here are ignored:
  - Register gain and set clipping = (peak == 2^(DW-1)-1).
  - gain_upd=1 only if gain changed.
  - Clear peak and count, then return to MEASURE.
- Latency: gain_upd and the new gain are visible 2 enabled cycles after the cycle that accepted the last window sample.
- gain is stable between UPDATE cycles. clipping holds until the next UPDATE.

Decomposition:
- Package agc_pkg: state enum (IDLE/MEASURE/DECIDE/UPDATE), GAIN_UNITY=64 constant, saturating-abs function.
- Sub-module agc_peak_detect: abs, window peak and sample counter. Outputs peak and win_done.
- FSM, hold counter and gain arithmetic live in agc_gain_ctrl.

Test Plan (defaults, target=64, hyst=8):
1. Reset, then idle -> gain=64, gain_upd=0, state IDLE for 1 cycle, then 01.
2. 16 valid samples of +100 -> gain 56; gain_upd pulses exactly 2 cycles after the 16th sample; hold=4.
3. Following windows of amplitude 20 -> no change for 4 windows, gain 57 after the 5th, then +1 per window.
4. A window containing -128 -> clipping=1 and gain decreases by 8. The next in-band window (amplitude 64) -> clipping=0, no gain_upd.
5. Continuous +120 from reset -> 64,56,…,8, then clamps to 1. A further loud window -> gain stays 1 with no gain_upd.
6. Edge conditions:
   - freeze=1 during loud windows -> gain constant.
   - clk_enable low for 5 cycles mid-window -> window still completes after 16 valid samples.
   - rst_n low mid-window -> gain returns to 64 immediately and the next window starts from count 0.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and helpers for the AGC gain sequencer.
//   agc_state_e : FSM state encoding, also exported on the state output
//   GAIN_UNITY  : gain word for unity in Q2.6
//   sat_abs     : saturating magnitude of a two's complement sample
package agc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StMeasure = 2'b01,
    StDecide  = 2'b10,
    StUpdate  = 2'b11
  } agc_state_e;

  localparam int unsigned GAIN_UNITY = 64;

  // |x| clipped to 2^(dw-1)-1 so the most negative code does not wrap.
  function automatic int sat_abs(input int x, input int dw);
    int lim;
    int a;
    lim = (1 << (dw - 1)) - 1;
    a   = (x < 0) ? -x : x;
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/agc_gain_ctrl_if.sv
// Sample stream, loop configuration and gain feedback of the AGC sequencer.
//   samp_in/samp_valid : post-gain datapath sample and qualifier
//   target/hyst        : desired peak magnitude and deadband half-width
//   freeze             : inhibit gain changes
//   gain/gain_upd      : gain word and one-cycle change pulse
//   state/clipping     : FSM state and full-scale flag of the last window
interface agc_gain_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned GW = 8
);
  logic signed [DW-1:0] samp_in;
  logic                 samp_valid;
  logic [DW-2:0]        target;
  logic [3:0]           hyst;
  logic                 freeze;
  logic [GW-1:0]        gain;
  logic                 gain_upd;
  logic [1:0]           state;
  logic                 clipping;

  modport master (
    output samp_in, samp_valid, target, hyst, freeze,
    input  gain, gain_upd, state, clipping
  );

  modport slave (
    input  samp_in, samp_valid, target, hyst, freeze,
    output gain, gain_upd, state, clipping
  );
endinterface

// File: rtl/agc_peak_detect.sv
// Window peak detector: saturating magnitude, running maximum and sample counter.
//   accept_i   : samples are only taken while high (MEASURE)
//   clear_i    : discard peak and count (UPDATE)
//   peak_o     : running maximum magnitude of the current window
//   win_done_o : high in the cycle that accepts the last sample of a window
module agc_peak_detect
  import agc_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_enable,
  input  logic signed [DW-1:0] samp_i,
  input  logic                 samp_valid_i,
  input  logic                 accept_i,
  input  logic                 clear_i,
  output logic [DW-2:0]        peak_o,
  output logic                 win_done_o
);

  logic [DW-2:0]       mag;
  logic [DW-2:0]       peak_q, peak_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                fire;

  always_comb begin
    mag        = (DW-1)'(sat_abs(int'(samp_i), DW));
    fire       = clk_enable & accept_i & samp_valid_i;
    // Count wraps to zero on the last sample; clear_i also zeroes it.
    win_done_o = fire & (cnt_q == '1);
    peak_o     = peak_q;
  end

  always_comb begin
    peak_d = peak_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      peak_d = '0;
      cnt_d  = '0;
    end else if (fire) begin
      if (mag > peak_q) peak_d = mag;
      cnt_d = cnt_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      cnt_q  <= '0;
    end else if (clk_enable) begin
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain sequencer. Measures the peak of each window of post-gain
// samples, compares it with target +/- hyst and steps the gain: fast attack on a
// loud window, slow release after HOLD quiet windows.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clk_enable  : low freezes all state
//   bus (slave) : sample stream, target/hyst/freeze in; gain, gain_upd,
//                 state, clipping out
// The new gain, gain_upd and clipping are written at the end of DECIDE, so
// they appear during UPDATE, two enabled cycles after the last window sample.
module agc_gain_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned DW           = 8,
  parameter int unsigned GW           = 8,
  parameter int unsigned WIN_LOG2     = 4,
  parameter int unsigned HOLD         = 4,
  parameter int unsigned ATTACK_STEP  = 8,
  parameter int unsigned RELEASE_STEP = 1,
  parameter int unsigned GAIN_INIT    = GAIN_UNITY,
  parameter int unsigned GAIN_MIN     = 1,
  parameter int unsigned GAIN_MAX     = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_enable,
  agc_gain_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  agc_state_e        state_q, state_d;
  logic [GW-1:0]     gain_q, gain_d;
  logic              gain_upd_q, gain_upd_d;
  logic              clip_q, clip_d;
  logic [HoldW-1:0]  hold_q, hold_d;

  logic [DW-2:0]     peak;
  logic              win_done;
  logic [DW-1:0]     tgt_ext, hyst_ext, thr_hi, thr_lo, peak_ext;
  logic              loud, quiet;
  logic [GW:0]       gain_ext, gain_sum;
  logic [GW-1:0]     gain_att, gain_rel;

  agc_peak_detect #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) u_peak (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .samp_i       (bus.samp_in),
    .samp_valid_i (bus.samp_valid),
    .accept_i     (state_q == StMeasure),
    .clear_i      (state_q == StUpdate),
    .peak_o       (peak),
    .win_done_o   (win_done)
  );

  // Deadband thresholds in DW bits: target+hyst cannot overflow, target-hyst
  // floors at zero.
  always_comb begin
    tgt_ext  = {1'b0, bus.target};
    hyst_ext = DW'(bus.hyst);
    peak_ext = {1'b0, peak};
    thr_hi   = tgt_ext + hyst_ext;
    thr_lo   = (tgt_ext > hyst_ext) ? (tgt_ext - hyst_ext) : '0;
    loud     = peak_ext > thr_hi;
    quiet    = peak_ext < thr_lo;
  end

  // Gain steps in GW+1 bits, then clamp into [GAIN_MIN, GAIN_MAX].
  always_comb begin
    gain_ext = {1'b0, gain_q};
    gain_att = (gain_ext >= (GW+1)'(ATTACK_STEP + GAIN_MIN))
             ? GW'(gain_ext - (GW+1)'(ATTACK_STEP)) : GW'(GAIN_MIN);
    gain_sum = gain_ext + (GW+1)'(RELEASE_STEP);
    gain_rel = (gain_sum > (GW+1)'(GAIN_MAX)) ? GW'(GAIN_MAX) : GW'(gain_sum);
  end

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    gain_upd_d = 1'b0;
    clip_d     = clip_q;
    hold_d     = hold_q;
    unique case (state_q)
      StIdle:    state_d = StMeasure;
      StMeasure: if (win_done) state_d = StDecide;
      StDecide: begin
        state_d = StUpdate;
        clip_d  = (peak == '1);
        if (!bus.freeze) begin
          if (loud) begin
            gain_d = gain_att;
            hold_d = HoldW'(HOLD);
          end else if (quiet) begin
            if (hold_q == '0) gain_d = gain_rel;
            else              hold_d = hold_q - HoldW'(1);
          end else if (hold_q != '0) begin
            hold_d = hold_q - HoldW'(1);
          end
        end
        gain_upd_d = (gain_d != gain_q);
      end
      StUpdate:  state_d = StMeasure;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gain_q     <= GW'(GAIN_INIT);
      gain_upd_q <= 1'b0;
      clip_q     <= 1'b0;
      hold_q     <= '0;
    end else if (clk_enable) begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      gain_upd_q <= gain_upd_d;
      clip_q     <= clip_d;
      hold_q     <= hold_d;
    end
  end

  // Masked so a stalled UPDATE cycle does not present the pulse twice.
  always_comb begin
    bus.gain     = gain_q;
    bus.gain_upd = gain_upd_q & clk_enable;
    bus.state    = state_q;
    bus.clipping = clip_q;
  end

endmodule
